// File: rtl/str_arb_pkg.sv
// Shared types for the str_arb round-robin packet arbiter.
package str_arb_pkg;
  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;
endpackage

// File: rtl/str_arb_rr_pick.sv
// Combinational round-robin pick: first set req bit after ptr, wrapping.
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  ptr,
  output logic                 any,
  output logic [ID_WIDTH-1:0]  idx
);
  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic                   found;
  int                     off;

  // Doubling req makes the rotate a plain shift; bit 0 of rot is port ptr+1.
  always_comb begin
    dbl   = {req, req} >> (32'(ptr) + 32'd1);
    rot   = dbl[NUM_PORTS-1:0];
    found = 1'b0;
    off   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        off   = i;
      end
    end
    any = |req;
    idx = ID_WIDTH'((32'(ptr) + 1 + off) % NUM_PORTS);
  end
endmodule

// File: rtl/str_arb.sv
// Round-robin packet arbiter: one grant per packet, one-deep registered output.
module str_arb
  import str_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] up_data,
  input  logic [NUM_PORTS-1:0]            up_last,
  input  logic [NUM_PORTS-1:0]            up_val,
  output logic [NUM_PORTS-1:0]            up_rdy,
  output logic [DATA_WIDTH-1:0]           dn_data,
  output logic [ID_WIDTH-1:0]             dn_id,
  output logic                            dn_last,
  output logic                            dn_val,
  input  logic                            dn_rdy
);
  state_t                               state, state_d;
  logic [ID_WIDTH-1:0]                  gnt, gnt_d, ptr, ptr_d, pick_idx;
  logic                                 pick_any, free, xfer;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] words;

  assign words = up_data;

  rr_pick #(.NUM_PORTS(NUM_PORTS), .ID_WIDTH(ID_WIDTH)) u_pick (
    .req (up_val),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign free = ~dn_val | dn_rdy;
  assign xfer = (state == S_LOCK) && up_val[gnt] && free;

  always_comb begin
    up_rdy = '0;
    if (state == S_LOCK) up_rdy[gnt] = free;
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    ptr_d   = ptr;
    case (state)
      S_IDLE: if (pick_any) begin
        gnt_d   = pick_idx;
        state_d = S_LOCK;
      end
      S_LOCK: if (xfer && up_last[gnt]) begin
        // Pointer moves only at packet end, so fairness is per packet.
        ptr_d   = gnt;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      gnt   <= '0;
      ptr   <= ID_WIDTH'(NUM_PORTS - 1);
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      ptr   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dn_val  <= 1'b0;
      dn_last <= 1'b0;
      dn_id   <= '0;
      dn_data <= '0;
    end else if (xfer) begin
      dn_val  <= 1'b1;
      dn_last <= up_last[gnt];
      dn_id   <= gnt;
      dn_data <= words[gnt];
    end else if (dn_rdy) begin
      dn_val  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_str_arb.sv
// Self-checking bench for str_arb: per-port source queues plus an expected-beat scoreboard.
module tb_str_arb;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NP*DW-1:0]  up_data = '0;
  logic [NP-1:0]     up_last = '0;
  logic [NP-1:0]     up_val = '0;
  logic [NP-1:0]     up_rdy;
  logic [DW-1:0]     dn_data;
  logic [IW-1:0]     dn_id;
  logic              dn_last;
  logic              dn_val;
  logic              dn_rdy = 1'b1;

  str_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .up_data(up_data), .up_last(up_last), .up_val(up_val),
    .up_rdy(up_rdy), .dn_data(dn_data), .dn_id(dn_id), .dn_last(dn_last),
    .dn_val(dn_val), .dn_rdy(dn_rdy)
  );

  always #5 clk = ~clk;

  logic [DW:0]   src_mem [NP][64];
  int            rd [NP];
  int            wr [NP];
  logic [NP-1:0] hold = '0;
  logic [NP-1:0] last_acc;
  beat_t         sb [$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            first_dn = -1;
  int            last_dn = -1;

  task automatic drive_inputs();
    for (int i = 0; i < NP; i++) begin
      logic [DW:0] w;
      w = (rd[i] < wr[i]) ? src_mem[i][rd[i]] : '0;
      up_val[i]          = (rd[i] < wr[i]) && !hold[i];
      up_last[i]         = w[DW];
      up_data[i*DW +: DW] = w[DW-1:0];
    end
  endtask

  task automatic send(input int p, input logic [DW-1:0] d, input logic l);
    beat_t e;
    src_mem[p][wr[p]] = {l, d};
    wr[p]++;
    e.id = IW'(p); e.last = l; e.data = d;
    sb.push_back(e);
  endtask

  // Observe at negedge, let the edge happen, then update sources; returns at posedge+2.
  task automatic tick();
    beat_t e, got;
    @(negedge clk);
    last_acc = up_val & up_rdy;
    if (dn_val && dn_rdy) begin
      got.id = dn_id; got.last = dn_last; got.data = dn_data;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got id=%0d last=%0b data=%h, expected no beat", dn_id, dn_last, dn_data);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL sb_beat: got id=%0d last=%0b data=%h, expected id=%0d last=%0b data=%h",
                   got.id, got.last, got.data, e.id, e.last, e.data);
        end
      end
      if (first_dn < 0) first_dn = cyc;
      last_dn = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NP; i++) if (last_acc[i]) rd[i]++;
    drive_inputs();
    #1;
  endtask

  function automatic logic srcs_busy();
    logic b = 1'b0;
    for (int i = 0; i < NP; i++) if (rd[i] < wr[i]) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name);
    int budget = 200;
    while ((sb.size() > 0 || srcs_busy() || dn_val) && budget > 0) begin
      tick();
      budget--;
    end
    n_vec++;
    if (budget == 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d beats still expected, required 0", name, sb.size());
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NP; i++) begin rd[i] = 0; wr[i] = 0; end
    hold = '0;
    sb.delete();
    drive_inputs();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    clear_all();
    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if ({dn_val, dn_last, dn_id, up_rdy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got val=%0b last=%0b id=%0d rdy=%b, required all 0", dn_val, dn_last, dn_id, up_rdy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_single_port();
    send(2, 8'h11, 1'b0); send(2, 8'h22, 1'b0); send(2, 8'h33, 1'b1);
    drive_inputs(); #1;
    n_vec++;
    if (up_rdy !== 4'b0000) begin n_err++; $display("FAIL sp_rdy_bubble: got %b, required 0000", up_rdy); end
    tick();
    n_vec++;
    if (up_rdy !== 4'b0100) begin n_err++; $display("FAIL sp_rdy_grant: got %b, required 0100", up_rdy); end
    first_dn = -1;
    drain("sp");
    n_vec++;
    if (last_dn - first_dn !== 2) begin
      n_err++; $display("FAIL sp_span: got %0d cycles, required 2", last_dn - first_dn);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b1);
    send(1, 8'h11, 1'b0); send(1, 8'h12, 1'b1);
    send(2, 8'h21, 1'b0); send(2, 8'h22, 1'b1);
    send(3, 8'h31, 1'b0); send(3, 8'h32, 1'b1);
    send(0, 8'h03, 1'b0); send(0, 8'h04, 1'b1);
    drive_inputs();
    first_dn = -1;
    drain("rr");
    n_vec++;
    if (last_dn - first_dn !== 13) begin
      n_err++; $display("FAIL rr_span: got %0d cycles, required 13", last_dn - first_dn);
    end
  endtask

  task automatic test_hold_mid_packet();
    int budget = 20;
    send(1, 8'hA1, 1'b0); send(1, 8'hA2, 1'b0); send(1, 8'hA3, 1'b1);
    send(3, 8'hD1, 1'b1);
    drive_inputs();
    last_acc = '0;
    while (!last_acc[1] && budget > 0) begin tick(); budget--; end
    n_vec++;
    if (budget == 0) begin n_err++; $display("FAIL hold_start_timeout: port 1 never accepted, required accept"); end
    hold[1] = 1'b1;
    drive_inputs();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (up_rdy !== 4'b0010) begin
        n_err++; $display("FAIL hold_blocked: cycle %0d got rdy=%b, required 0010", k, up_rdy);
      end
    end
    hold[1] = 1'b0;
    drive_inputs();
    drain("hold");
  endtask

  task automatic test_stall();
    int budget = 10;
    send(2, 8'hB0, 1'b0); send(2, 8'hB1, 1'b0); send(2, 8'hB2, 1'b0); send(2, 8'hB3, 1'b1);
    dn_rdy = 1'b0;
    drive_inputs();
    while (!dn_val && budget > 0) begin tick(); budget--; end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if ({dn_val, dn_id, dn_data, up_rdy} !== {1'b1, 2'd2, 8'hB0, 4'b0000}) begin
        n_err++;
        $display("FAIL stall_hold: cycle %0d got val=%0b id=%0d data=%h rdy=%b, required val=1 id=2 data=b0 rdy=0000",
                 k, dn_val, dn_id, dn_data, up_rdy);
      end
    end
    dn_rdy = 1'b1;
    drain("stall");
  endtask

  task automatic test_single_beat();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      send(0, 8'(8'hC0 + k), 1'b1);
      send(3, 8'(8'hE0 + k), 1'b1);
    end
    drive_inputs();
    drain("sbeat");
  endtask

  task automatic test_reset_mid();
    int budget = 20;
    send(1, 8'h51, 1'b0); send(1, 8'h52, 1'b0); send(1, 8'h53, 1'b0); send(1, 8'h54, 1'b1);
    drive_inputs();
    while (sb.size() > 3 && budget > 0) begin tick(); budget--; end
    n_vec++;
    if (dn_val !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got dn_val=%0b, required 1", dn_val); end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({dn_val, up_rdy} !== 5'b0) begin
      n_err++; $display("FAIL rmid_async: got val=%0b rdy=%b, required val=0 rdy=0000", dn_val, up_rdy);
    end
    clear_all();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    send(0, 8'h61, 1'b1);
    send(1, 8'h71, 1'b1);
    drive_inputs();
    drain("rmid");
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin rd[i] = 0; wr[i] = 0; end
    test_reset();
    test_single_port();
    test_round_robin();
    test_hold_mid_packet();
    test_stall();
    test_single_beat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
